// File: rtl/pipe_hs_reg_pkg.sv
// Shared pipeline definitions for handshaked stage registers.
//   pipe_state_e : occupancy state of a stage (empty / one entry / two entries)
//   pipe_count   : number of held entries for a given state
package pipe_hs_reg_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_BUSY  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] pipe_count(input pipe_state_e s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      PIPE_BUSY: n = 2'd1;
      PIPE_FULL: n = 2'd2;
      default:   n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_hs_reg_stdreg.sv
// Plain payload register with write enable and asynchronous active-low reset.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset, loads RESET_VAL
//   i_we    : write enable
//   i_d     : next payload
//   o_q     : held payload
module pipe_hs_reg_stdreg #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= RESET_VAL;
    end else if (i_we) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/pipe_hs_reg.sv
// Generic pipeline stage register with valid/ready handshake, flush and an
// optional skid entry. Output data always comes from the main entry; the skid
// entry only catches the word that arrives while downstream stalls, so that
// the upstream ready can come straight from a flop (SKID=1).
// Ports:
//   i_clk, i_rst_n            : clock (rising edge), async active-low reset
//   i_flush                   : drop all held entries at the next edge
//   i_pre_valid/o_pre_ready   : upstream handshake, i_pre_data payload
//   o_post_valid/i_post_ready : downstream handshake, o_post_data payload
//   o_count                   : number of held entries (0..2)
module pipe_hs_reg
  import pipe_hs_reg_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SKID      = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_pre_valid,
  output logic             o_pre_ready,
  input  logic [WIDTH-1:0] i_pre_data,
  output logic             o_post_valid,
  input  logic             i_post_ready,
  output logic [WIDTH-1:0] o_post_data,
  output logic [1:0]       o_count
);

  pipe_state_e      state, state_nxt;
  logic             xfer_in, xfer_out;
  logic             main_we, skid_we, main_from_skid;
  logic [WIDTH-1:0] main_d, skid_data;

  assign xfer_in      = i_pre_valid & o_pre_ready;
  assign xfer_out     = o_post_valid & i_post_ready;
  assign o_post_valid = (state != PIPE_EMPTY);
  assign o_count      = pipe_count(state);

  always_comb begin
    state_nxt      = state;
    main_we        = 1'b0;
    skid_we        = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      PIPE_EMPTY: begin
        if (xfer_in) begin
          state_nxt = PIPE_BUSY;
          main_we   = 1'b1;
        end
      end
      PIPE_BUSY: begin
        if (xfer_in && xfer_out) begin
          main_we = 1'b1;
        end else if (xfer_in) begin
          // Only reachable with a skid entry: with SKID=0 the combinational
          // ready guarantees an accepted word always coincides with a drain.
          if (SKID != 0) begin
            state_nxt = PIPE_FULL;
            skid_we   = 1'b1;
          end
        end else if (xfer_out) begin
          state_nxt = PIPE_EMPTY;
        end
      end
      PIPE_FULL: begin
        if (xfer_out) begin
          state_nxt      = PIPE_BUSY;
          main_we        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = PIPE_EMPTY;
    endcase
    // Flush wins over everything, including a word handshaked this cycle.
    if (i_flush) begin
      state_nxt = PIPE_EMPTY;
      main_we   = 1'b0;
      skid_we   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= PIPE_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  generate
    if (SKID != 0) begin : g_reg_ready
      // Ready is precomputed from the next state so it is a pure flop output.
      logic ready_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ready_q <= 1'b1;
        end else begin
          ready_q <= (state_nxt != PIPE_FULL);
        end
      end
      assign o_pre_ready = ready_q;
    end else begin : g_comb_ready
      assign o_pre_ready = ~o_post_valid | i_post_ready;
    end
  endgenerate

  assign main_d = main_from_skid ? skid_data : i_pre_data;

  // Stage boundary: main entry drives the downstream payload
  pipe_hs_reg_stdreg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (main_we),
    .i_d     (main_d),
    .o_q     (o_post_data)
  );

  pipe_hs_reg_stdreg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (skid_we),
    .i_d     (i_pre_data),
    .o_q     (skid_data)
  );

endmodule

// File: doc/pipe_hs_reg.md
Name: pipe_hs_reg

Overview:
- Generic, parametrised pipeline stage register with valid/ready handshake, flush, and an optional skid entry.
- Successor to the fixed-width, always-enabled inter-stage registers (if/id, id/ex, ex/ls, ls/wb). It carries an arbitrary packed payload and supports back-pressure and bubbles.
- Sits between any two pipeline stages.
- With SKID=1, o_pre_ready is driven from a flop, which cuts the combinational ready path across the stage boundary.

Parameters:
- WIDTH, 64: payload width in bits; must be ≥1.
- RESET_VAL, 0: reset value of every payload register, WIDTH bits.
- SKID, 1: 0 = single entry with combinational ready; 1 = two entries (main + skid) with registered ready and full throughput.

Ports:
- i_clk, input, 1: clock, rising edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_flush, input, 1: discard all held entries; synchronous; highest priority.
- i_pre_valid, input, 1: upstream holds a valid payload.
- o_pre_ready, output, 1: this stage accepts the payload this cycle.
- i_pre_data, input, WIDTH: upstream payload.
- o_post_valid, output, 1: o_post_data is valid.
- i_post_ready, input, 1: downstream accepts this cycle.
- o_post_data, output, WIDTH: payload toward the next stage, always taken from the main entry.
- o_count, output, 2: number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Handshake rules:
  - Transfer in = i_pre_valid & o_pre_ready.
  - Transfer out = o_post_valid & i_post_ready.
  - Evaluated at the rising edge of i_clk.
- Reset (asynchronous assert, synchronous release):
  - o_post_valid=0, o_post_data=RESET_VAL, skid data=RESET_VAL, o_count=0.
  - o_pre_ready=1 for SKID=1; for SKID=0 it follows its combinational equation.
- Latency: one cycle from accepted input to o_post_valid. There is no combinational data path from input to output.
- SKID=0:
  - o_pre_ready = ~o_post_valid | i_post_ready (combinational).
  - On transfer in, the main entry loads i_pre_data and o_post_valid=1.
  - On transfer out without transfer in, o_post_valid=0.
  - The payload holds while o_post_valid & ~i_post_ready.
- SKID=1 uses three states, with o_pre_ready = (state != FULL), registered:
  - EMPTY:
    - in → BUSY (main loads).
  - BUSY:
    - in & out → BUSY (main reloads).
    - in & ~out → FULL (skid loads input).
    - ~in & out → EMPTY.
    - otherwise stay.
  - FULL:
    - out → BUSY (main loads skid).
    - otherwise stay. No input is accepted in FULL.
- SKID=1 throughput: sustains 1 transfer/cycle when i_post_ready is held high.
- Flush:
  - At the next edge, state=EMPTY, o_post_valid=0, o_count=0.
  - Any same-cycle input is discarded, even if it was handshaked.
  - Payload registers are not cleared.
  - o_pre_ready returns to 1 the cycle after the flush.
- Ordering: strict FIFO. The skid entry is never emitted before the main entry.
- Stability: while o_post_valid & ~i_post_ready, o_post_data and o_post_valid must not change (flush excepted).
- Reset mid-transfer: all held data is lost; no output glitch is permitted beyond the asynchronous clear.
- Upstream changing i_pre_data while not accepted is legal and has no effect.

Decomposition:
- `CPU_WIDTH and `REG_ADDRW come from config.sv. Callers set WIDTH from those sums.
- The new localparam-style state encodings go in a shared pipeline package:
  - PIPE_EMPTY=2'd0, PIPE_BUSY=2'd1, PIPE_FULL=2'd2.
- Sub-module: the main and skid payload registers are each one stdreg instance, with write enable driven by the control FSM.
- The control FSM stays in this module.

Test Plan:
1. Reset: hold i_rst_n=0 mid-cycle with i_pre_valid=1, i_pre_data=0xA5 → o_post_valid=0, o_post_data=RESET_VAL, o_count=0 asynchronously; o_pre_ready=1 after release (SKID=1).
2. Streaming: i_post_ready=1, send 0x01..0x10 back-to-back → outputs 0x01..0x10 in order, one per cycle, first one cycle after accept, o_count never exceeds 1.
3. Back-pressure (SKID=1): accept 0x11, 0x22, then drop i_post_ready for 3 cycles → o_count=2, o_pre_ready=0, o_post_data held at 0x11; on release, 0x11 then 0x22 emitted, then o_pre_ready=1.
4. SKID=0 pass-through ready: o_post_valid=1, i_post_ready=1, new input 0x33 → accepted the same cycle, output 0x33 next cycle with no bubble.
5. Flush in FULL with concurrent input 0x44 → next cycle o_post_valid=0, o_count=0; 0x44 never appears on the output.
6. Random valid/ready (10k cycles, both SKID values) against a scoreboard → no loss, no duplication, order preserved, output stable under stall.
